// File: rtl/mips_trace_buffer_pkg.sv
// Shared encodings and helpers for the MIPS trace capture buffer.
`timescale 1ns/1ps
package mips_trace_buffer_pkg;

  // Capture state as seen on oState
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Trigger source selection as seen on iMode
  typedef enum logic [1:0] {
    TRIG_PC   = 2'd0,
    TRIG_EXT  = 2'd1,
    TRIG_ANY  = 2'd2,
    TRIG_FILL = 2'd3
  } mode_e;

  // Ceiling log2 for sizing pointers and indices (clog2(1) = 0)
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_trace_buffer_trace_ram.sv
// Simple dual-port sample store: one full sample per row, registered
// single-channel read so the output can drive the readout port directly.
`timescale 1ns/1ps
module mips_trace_buffer_trace_ram
  import mips_trace_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned CW    = (N_CH > 1) ? clog2(N_CH) : 1
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [N_CH*DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]          i_rd_addr,
  input  logic [CW-1:0]          i_rd_ch,
  output logic [DATA_W-1:0]      o_rd_data
);

  logic [N_CH-1:0][DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0]           r_rd_data;

  // Sample write; array contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read of the selected channel lane
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_data <= '0;
    else          r_rd_data <= r_mem[i_rd_addr][i_rd_ch];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mips_trace_buffer.sv
// Circular trace capture for the MIPS core: samples N_CH debug words per
// commit strobe, triggers on PC match / external event / arm, and keeps a
// pre/post-trigger window for random-access readout.
`timescale 1ns/1ps
module mips_trace_buffer
  import mips_trace_buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_CH      = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4,
  localparam int unsigned AW       = clog2(DEPTH),
  localparam int unsigned CW       = (N_CH > 1) ? clog2(N_CH) : 1,
  localparam int unsigned NW       = AW + 1
)(
  input  logic                   iCLK,
  input  logic                   iRST_n,
  input  logic                   iSample,
  input  logic [N_CH*DATA_W-1:0] iCh,
  input  logic                   iArm,
  input  logic [1:0]             iMode,
  input  logic [DATA_W-1:0]      iTrigPC,
  input  logic [DATA_W-1:0]      iTrigMask,
  input  logic                   iTrigExt,
  input  logic [AW-1:0]          iRdIdx,
  input  logic [CW-1:0]          iRdCh,
  output logic [DATA_W-1:0]      oRdData,
  output logic [1:0]             oState,
  output logic [NW-1:0]          oCount,
  output logic [AW-1:0]          oTrigIdx,
  output logic                   oDone
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [AW-1:0]   r_wr_ptr,  w_ptr_nxt;
  logic [NW-1:0]   r_count,   w_cnt_nxt;
  logic [NW-1:0]   r_post,    w_post_nxt;
  logic [AW-1:0]   r_trig_idx, w_trig_nxt;
  logic            r_done;
  logic            w_wr_en;
  mode_e           w_mode;
  logic            w_pc_hit;
  logic            w_trig;
  logic [NW-1:0]   w_cnt_inc;
  logic [AW-1:0]   w_done_idx;
  logic [AW-1:0]   w_oldest;
  logic [AW-1:0]   w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_mode     = mode_e'(iMode);
  assign w_pc_hit   = ((iCh[DATA_W-1:0] ^ iTrigPC) & iTrigMask) == '0;
  assign w_cnt_inc  = (r_count == NW'(DEPTH)) ? r_count : r_count + NW'(1);
  // Trigger position once the window closes: last store minus the post window
  assign w_done_idx = AW'(w_cnt_inc - NW'(1) - NW'(POST_TRIG));
  // Once the buffer has wrapped, the oldest sample sits at the write pointer
  assign w_oldest   = (r_count == NW'(DEPTH)) ? r_wr_ptr : '0;
  assign w_rd_addr  = w_oldest + iRdIdx;

  // Trigger source decode for the current mode
  always_comb begin
    w_trig = 1'b0;
    case (w_mode)
      TRIG_PC:  w_trig = w_pc_hit;
      TRIG_EXT: w_trig = iTrigExt;
      TRIG_ANY: w_trig = w_pc_hit | iTrigExt;
      default:  w_trig = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state, pointer and counter logic; arm wins over a same-cycle sample
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_ptr_nxt   = r_wr_ptr;
    w_cnt_nxt   = r_count;
    w_post_nxt  = r_post;
    w_trig_nxt  = r_trig_idx;
    if (iArm) begin
      w_ptr_nxt  = '0;
      w_cnt_nxt  = '0;
      w_trig_nxt = '0;
      if (w_mode == TRIG_FILL) begin
        w_state_nxt = ST_POST;
        w_post_nxt  = NW'(DEPTH);
      end else begin
        w_state_nxt = ST_PRE;
        w_post_nxt  = '0;
      end
    end else if (iSample) begin
      case (r_state)
        ST_PRE: begin
          w_wr_en   = 1'b1;
          w_ptr_nxt = r_wr_ptr + AW'(1);
          w_cnt_nxt = w_cnt_inc;
          if (w_trig) begin
            if (POST_TRIG == 0) begin
              w_state_nxt = ST_DONE;
              w_trig_nxt  = w_done_idx;
            end else begin
              w_state_nxt = ST_POST;
              w_post_nxt  = NW'(POST_TRIG);
            end
          end
        end
        ST_POST: begin
          w_wr_en    = 1'b1;
          w_ptr_nxt  = r_wr_ptr + AW'(1);
          w_cnt_nxt  = w_cnt_inc;
          w_post_nxt = r_post - NW'(1);
          if (r_post == NW'(1)) begin
            w_state_nxt = ST_DONE;
            w_trig_nxt  = (w_mode == TRIG_FILL) ? '0 : w_done_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointer, counters and status registers
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post     <= '0;
      r_trig_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_wr_ptr   <= w_ptr_nxt;
      r_count    <= w_cnt_nxt;
      r_post     <= w_post_nxt;
      r_trig_idx <= w_trig_nxt;
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  mips_trace_buffer_trace_ram #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk     (iCLK),
    .i_rst_n   (iRST_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (iCh),
    .i_rd_addr (w_rd_addr),
    .i_rd_ch   (iRdCh),
    .o_rd_data (w_rd_data)
  );

  assign oRdData  = w_rd_data;
  assign oState   = r_state;
  assign oCount   = r_count;
  assign oTrigIdx = r_trig_idx;
  assign oDone    = r_done;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer (default parameters).
`timescale 1ns/1ps
module tb_mips_trace_buffer;

  localparam int POST = 4;
  localparam int DEP  = 16;

  logic        iCLK;
  logic        iRST_n;
  logic        iSample;
  logic [63:0] iCh;
  logic        iArm;
  logic [1:0]  iMode;
  logic [31:0] iTrigPC;
  logic [31:0] iTrigMask;
  logic        iTrigExt;
  logic [3:0]  iRdIdx;
  logic [0:0]  iRdCh;
  logic [31:0] oRdData;
  logic [1:0]  oState;
  logic [4:0]  oCount;
  logic [3:0]  oTrigIdx;
  logic        oDone;

  int total = 0;
  int bad   = 0;

  mips_trace_buffer dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iSample   (iSample),
    .iCh       (iCh),
    .iArm      (iArm),
    .iMode     (iMode),
    .iTrigPC   (iTrigPC),
    .iTrigMask (iTrigMask),
    .iTrigExt  (iTrigExt),
    .iRdIdx    (iRdIdx),
    .iRdCh     (iRdCh),
    .oRdData   (oRdData),
    .oState    (oState),
    .oCount    (oCount),
    .oTrigIdx  (oTrigIdx),
    .oDone     (oDone)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] trig_pc;
    logic [31:0] mask;
    logic [31:0] pc0;
    int          n_samp;
    int          ext_at;
    int          n_stored;
    int          exp_count;
    int          exp_tidx;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ch_word(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_5A5A, pc};
  endfunction

  // All drivers start and end on a falling edge
  task automatic drive_sample(input logic [31:0] pc, input logic ext);
    iCh = ch_word(pc); iTrigExt = ext; iSample = 1'b1;
    @(negedge iCLK);
    iSample = 1'b0; iTrigExt = 1'b0;
  endtask

  task automatic arm(input logic [1:0] m, input logic smp, input logic ext);
    iMode = m; iArm = 1'b1; iSample = smp; iTrigExt = ext;
    @(negedge iCLK);
    iArm = 1'b0; iSample = 1'b0; iTrigExt = 1'b0;
  endtask

  // Stream reads of both channels; expected word queued when the index is driven
  task automatic read_window(input int vi);
    vec_t v;
    v = vecs[vi];
    for (int i = 0; i < v.exp_count * 2; i++) begin
      int          idx;
      int          ch;
      int          s;
      logic [31:0] pc;
      logic [31:0] e;
      idx = i / 2;
      ch  = i % 2;
      s   = v.n_stored - v.exp_count + idx;
      pc  = v.pc0 + 32'(4 * s);
      iRdIdx = 4'(idx);
      iRdCh  = 1'(ch);
      exp_q.push_back((ch == 1) ? (pc ^ 32'hA5A5_5A5A) : pc);
      @(negedge iCLK);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_rd_idx%0d_ch%0d", vi, idx, ch), oRdData, e);
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   t;
    v = vecs[vi];
    t = v.n_stored - 1 - POST;
    iTrigPC = v.trig_pc; iTrigMask = v.mask;
    arm(v.mode, 1'b0, 1'b0);
    chk($sformatf("v%0d_arm_state", vi), 32'(oState), (v.mode == 2'd3) ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_arm_count", vi), 32'(oCount), 32'd0);
    for (int s = 0; s < v.n_samp; s++) begin
      int es;
      int ec;
      ec = (s + 1 < v.n_stored) ? s + 1 : v.n_stored;
      if (ec > DEP) ec = DEP;
      if (s + 1 >= v.n_stored)            es = 3;
      else if (v.mode == 2'd3 || s >= t)  es = 2;
      else                                es = 1;
      drive_sample(v.pc0 + 32'(4 * s), 1'(s == v.ext_at));
      chk($sformatf("v%0d_s%0d_state", vi, s), 32'(oState), 32'(es));
      chk($sformatf("v%0d_s%0d_count", vi, s), 32'(oCount), 32'(ec));
      chk($sformatf("v%0d_s%0d_done", vi, s), 32'(oDone), 32'(es == 3));
    end
    chk($sformatf("v%0d_count", vi), 32'(oCount), 32'(v.exp_count));
    chk($sformatf("v%0d_trig_idx", vi), 32'(oTrigIdx), 32'(v.exp_tidx));
    read_window(vi);
  endtask

  initial begin
    iRST_n = 1'b1; iSample = 1'b0; iArm = 1'b0; iMode = 2'd0;
    iTrigPC = '0; iTrigMask = '0; iTrigExt = 1'b0; iCh = '0;
    iRdIdx = '0; iRdCh = '0;

    //            mode  trig_pc        mask           pc0            n_samp ext stored cnt tidx
    vecs[0] = '{2'd0, 32'h0040_0020, 32'hFFFF_FFFF, 32'h0040_0000, 16, -1, 13, 13,  8};
    vecs[1] = '{2'd0, 32'h0040_009C, 32'hFFFF_FFFF, 32'h0040_0000, 47, -1, 44, 16, 11};
    vecs[2] = '{2'd3, 32'h0000_0000, 32'hFFFF_FFFF, 32'h2000_0000, 17, -1, 16, 16,  0};
    vecs[3] = '{2'd1, 32'h0040_0000, 32'hFFFF_FFFF, 32'h0040_0000, 12,  6, 11, 11,  6};
    vecs[4] = '{2'd2, 32'h3000_0010, 32'hFFFF_FFFF, 32'h3000_0000, 12,  9,  9,  9,  4};
    vecs[5] = '{2'd2, 32'hDEAD_0000, 32'hFFFF_FFFF, 32'h3000_0000, 10,  2,  7,  7,  2};
    vecs[6] = '{2'd0, 32'h0000_0030, 32'h0000_00FF, 32'h5000_0000, 20, -1, 17, 16, 11};
    vecs[7] = '{2'd0, 32'h6000_0000, 32'hFFFF_FFFF, 32'h6000_0000,  8, -1,  5,  5,  0};

    // Reset state
    #1 iRST_n = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_trig_idx", 32'(oTrigIdx), 32'd0);
    chk("rst_rd_data", oRdData, 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    iRST_n = 1'b1;
    @(negedge iCLK);

    // Sample while idle is not captured
    drive_sample(32'h0000_1000, 1'b1);
    chk("idle_state", 32'(oState), 32'd0);
    chk("idle_count", 32'(oCount), 32'd0);

    for (int vi = 0; vi < 8; vi++) run_vec(vi);

    // Masked compare: upper bits and low-byte-don't-care
    iTrigPC = 32'h1000_0000; iTrigMask = 32'hFFFF_FF00;
    arm(2'd0, 1'b0, 1'b0);
    drive_sample(32'h1000_01F4, 1'b1);
    chk("mask_nohit_state", 32'(oState), 32'd1);
    chk("mask_nohit_count", 32'(oCount), 32'd1);
    iCh = ch_word(32'h1000_0000);
    @(negedge iCLK);
    chk("nosample_state", 32'(oState), 32'd1);
    chk("nosample_count", 32'(oCount), 32'd1);
    drive_sample(32'h1000_00F4, 1'b0);
    chk("mask_hit_state", 32'(oState), 32'd2);
    chk("mask_hit_count", 32'(oCount), 32'd2);

    // Arm and sample together in external mode: sample discarded
    arm(2'd1, 1'b1, 1'b1);
    chk("armsmp_state", 32'(oState), 32'd1);
    chk("armsmp_count", 32'(oCount), 32'd0);
    drive_sample(32'h0000_0100, 1'b1);
    chk("armsmp_trig_state", 32'(oState), 32'd2);
    chk("armsmp_trig_count", 32'(oCount), 32'd1);
    for (int i = 0; i < POST; i++) drive_sample(32'h0000_0104 + 32'(4 * i), 1'b0);
    chk("armsmp_done_state", 32'(oState), 32'd3);
    chk("armsmp_done_count", 32'(oCount), 32'd5);
    chk("armsmp_trig_idx", 32'(oTrigIdx), 32'd0);
    iRdIdx = 4'd0; iRdCh = 1'b0;
    exp_q.push_back(32'h0000_0100);
    @(negedge iCLK);
    chk("armsmp_rd_trig", oRdData, exp_q.pop_front());

    // Asynchronous reset in the middle of the post window
    iTrigPC = 32'h7000_0000; iTrigMask = 32'hFFFF_FFFF;
    arm(2'd0, 1'b0, 1'b0);
    drive_sample(32'h7000_0000, 1'b0);
    drive_sample(32'h7000_0004, 1'b0);
    chk("prerst_state", 32'(oState), 32'd2);
    #2 iRST_n = 1'b0;
    #0.5;
    chk("async_rst_state", 32'(oState), 32'd0);
    chk("async_rst_count", 32'(oCount), 32'd0);
    chk("async_rst_rd_data", oRdData, 32'd0);
    #0.5 iRST_n = 1'b1;
    @(negedge iCLK);
    drive_sample(32'h7000_0008, 1'b0);
    chk("postrst_state", 32'(oState), 32'd0);
    chk("postrst_count", 32'(oCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
